// File: rtl/contador_pkg.sv
// contador_pkg: shared types and constants for the debounced 4-bit counter controller
// Holds the FSM state encoding, the count width, the synchroniser depth and the load saturation helper.
package contador_pkg;
    localparam int LARG_CONT = 4;
    localparam int PROF_SYNC = 2;
    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        FIM      = 2'b11
    } estado_t;
    // Load values beyond the count range clamp to the last valid count.
    function automatic logic [LARG_CONT-1:0] satura(input logic [LARG_CONT-1:0] v, input int modulo);
        return (int'(v) >= modulo) ? LARG_CONT'(modulo - 1) : v;
    endfunction
endpackage

// File: rtl/filtro_botao.sv
// filtro_botao: synchroniser, debounce filter and rising-edge event for one raw push-button
// Ports:
//   clock_i   system clock
//   reset_i   asynchronous active-high reset
//   botao_i   raw button level, asynchronous to clock_i
//   evento_o  1-cycle pulse when the filtered level rises
module filtro_botao
    import contador_pkg::*;
#(
    parameter int DEB_CICLOS = 1_000_000
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic botao_i,
    output logic evento_o
);
    localparam int CW = $clog2(DEB_CICLOS + 1);
    logic [PROF_SYNC-1:0] sinc_q;
    logic [CW-1:0]        cont_q, cont_d;
    logic                 nivel_q, nivel_d, nivel_ant_q;
    logic                 amostra;
    assign amostra = sinc_q[PROF_SYNC-1];
    // The counter only runs while the synchronised sample disagrees with the accepted level,
    // so any bounce back to the old level restarts the stability window.
    always_comb begin
        cont_d  = '0;
        nivel_d = nivel_q;
        if (amostra != nivel_q) begin
            if (cont_q == CW'(DEB_CICLOS - 1)) nivel_d = amostra;
            else cont_d = cont_q + 1'b1;
        end
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sinc_q      <= '0;
            cont_q      <= '0;
            nivel_q     <= 1'b0;
            nivel_ant_q <= 1'b0;
        end else begin
            sinc_q      <= {sinc_q[PROF_SYNC-2:0], botao_i};
            cont_q      <= cont_d;
            nivel_q     <= nivel_d;
            nivel_ant_q <= nivel_q;
        end
    end
    assign evento_o = nivel_q & ~nivel_ant_q;
endmodule

// File: rtl/controle_contador_filtro.sv
// controle_contador_filtro: button-driven run/pause/load/end controller owning the display count S
// Ports:
//   clock, reset                          single clock domain, asynchronous active-high reset
//   botao_inicio, botao_pausa, botao_carga raw buttons (debounced internally)
//   modo_desc                             0 count up, 1 count down (synchronised level)
//   valor_carga                           value loaded into S on a load event
//   S                                     count value for the 7-segment decoder
//   tick_out                              1-cycle pulse on every count step
//   fim                                   terminal indication (pulse when cyclic, level in FIM otherwise)
//   estado                                current FSM state
module controle_contador_filtro
    import contador_pkg::*;
#(
    parameter int DIV_TICK   = 50_000_000,
    parameter int DEB_CICLOS = 1_000_000,
    parameter int MODULO     = 10,
    parameter bit CICLICO    = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 botao_inicio,
    input  logic                 botao_pausa,
    input  logic                 botao_carga,
    input  logic                 modo_desc,
    input  logic [LARG_CONT-1:0] valor_carga,
    output logic [LARG_CONT-1:0] S,
    output logic                 tick_out,
    output logic                 fim,
    output logic [1:0]           estado
);
    localparam int                   PW    = $clog2(DIV_TICK + 1);
    localparam logic [LARG_CONT-1:0] MAX   = LARG_CONT'(MODULO - 1);
    localparam logic [PW-1:0]        P_MAX = PW'(DIV_TICK - 1);
    logic                 ev_inicio, ev_pausa, ev_carga;
    logic                 carga, pausa, inicio, tick, terminal, desc, volta;
    logic [PROF_SYNC-1:0] modo_q;
    estado_t              estado_q, estado_d;
    logic [LARG_CONT-1:0] s_q, s_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 tick_q, tick_d, fim_q, fim_d;
    filtro_botao #(.DEB_CICLOS(DEB_CICLOS)) u_inicio (
        .clock_i(clock), .reset_i(reset), .botao_i(botao_inicio), .evento_o(ev_inicio)
    );
    filtro_botao #(.DEB_CICLOS(DEB_CICLOS)) u_pausa (
        .clock_i(clock), .reset_i(reset), .botao_i(botao_pausa), .evento_o(ev_pausa)
    );
    filtro_botao #(.DEB_CICLOS(DEB_CICLOS)) u_carga (
        .clock_i(clock), .reset_i(reset), .botao_i(botao_carga), .evento_o(ev_carga)
    );
    // Event priority carga > pausa > inicio; a masked event is dropped, not deferred.
    assign carga    = ev_carga;
    assign pausa    = ev_pausa & ~ev_carga;
    assign inicio   = ev_inicio & ~ev_pausa & ~ev_carga;
    assign desc     = modo_q[PROF_SYNC-1];
    assign tick     = (estado_q == CONTANDO) && (presc_q == P_MAX);
    assign terminal = desc ? (s_q == '0) : (s_q == MAX);
    always_comb begin
        estado_d = estado_q;
        s_d      = s_q;
        presc_d  = presc_q;
        volta    = 1'b0;
        if (carga) begin
            s_d      = satura(valor_carga, MODULO);
            estado_d = PARADO;
        end else begin
            case (estado_q)
                PARADO: if (inicio) estado_d = CONTANDO;
                CONTANDO: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick && !terminal) s_d = desc ? s_q - 1'b1 : s_q + 1'b1;
                    if (tick && terminal && CICLICO) begin
                        s_d   = desc ? MAX : '0;
                        volta = 1'b1;
                    end
                    // Reaching the end wins over a pause arriving in the same cycle.
                    if (tick && terminal && !CICLICO) estado_d = FIM;
                    else if (pausa) estado_d = PAUSADO;
                end
                PAUSADO: if (pausa || inicio) estado_d = CONTANDO;
                default: if (inicio) begin
                    s_d      = desc ? MAX : '0;
                    estado_d = CONTANDO;
                end
            endcase
        end
        // Prescaler phase survives a pause but restarts from any idle state.
        if (estado_d == PARADO || estado_d == FIM) presc_d = '0;
        tick_d = tick & ~carga;
        fim_d  = CICLICO ? volta : (estado_d == FIM);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            modo_q   <= '0;
            estado_q <= PARADO;
            s_q      <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            modo_q   <= {modo_q[PROF_SYNC-2:0], modo_desc};
            estado_q <= estado_d;
            s_q      <= s_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            fim_q    <= fim_d;
        end
    end
    assign S        = s_q;
    assign estado   = estado_q;
    assign tick_out = tick_q;
    assign fim      = fim_q;
endmodule

// File: tb/tb_controle_contador_filtro.sv
// tb_controle_contador_filtro: directed scenarios plus random button traffic against a cycle model
module tb_controle_contador_filtro;
    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int MOD = 10;
    logic       clock = 1'b0, reset = 1'b1;
    logic       botao_inicio = 1'b0, botao_pausa = 1'b0, botao_carga = 1'b0, modo_desc = 1'b0;
    logic [3:0] valor_carga = 4'd0;
    logic [3:0] s_c, s_f;
    logic [1:0] st_c, st_f;
    logic       tk_c, tk_f, fm_c, fm_f;
    int         checks = 0, failures = 0;
    // model state: button sample histories, filtered levels, and per-instance outputs
    // (instance 0 is cyclic, instance 1 stops in FIM)
    bit         hb[3][DEB+2];
    bit         hm[3];
    bit         fl[3], fl_ant[3];
    int         ms[2], mst[2], mpr[2];
    bit         mtk[2], mfm[2];
    always #5 clock = ~clock;
    controle_contador_filtro #(.DIV_TICK(DIV), .DEB_CICLOS(DEB), .MODULO(MOD), .CICLICO(1'b1)) u_cic (
        .clock(clock), .reset(reset), .botao_inicio(botao_inicio), .botao_pausa(botao_pausa),
        .botao_carga(botao_carga), .modo_desc(modo_desc), .valor_carga(valor_carga),
        .S(s_c), .tick_out(tk_c), .fim(fm_c), .estado(st_c)
    );
    controle_contador_filtro #(.DIV_TICK(DIV), .DEB_CICLOS(DEB), .MODULO(MOD), .CICLICO(1'b0)) u_fim (
        .clock(clock), .reset(reset), .botao_inicio(botao_inicio), .botao_pausa(botao_pausa),
        .botao_carga(botao_carga), .modo_desc(modo_desc), .valor_carga(valor_carga),
        .S(s_f), .tick_out(tk_f), .fim(fm_f), .estado(st_f)
    );
    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, esp, $time);
        end
    endtask
    task automatic reset_modelo();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < DEB + 2; k++) hb[b][k] = 1'b0;
            fl[b] = 1'b0;
            fl_ant[b] = 1'b0;
            hm[b] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mst[i] = 0; mpr[i] = 0; mtk[i] = 1'b0; mfm[i] = 1'b0;
        end
    endtask
    // One rising edge of the reference: a level is accepted once the last DEB synchronised
    // samples (two edges old and older) all disagree with it; events are accepted-level rises.
    task automatic passo_modelo();
        bit raw[3];
        bit ev[3];
        bit todos, dir, carga, pausa, inicio, cic, volta;
        int ld, term, passo;
        raw = '{botao_inicio, botao_pausa, botao_carga};
        for (int b = 0; b < 3; b++) begin
            ev[b] = fl[b] & ~fl_ant[b];
            for (int k = DEB + 1; k > 0; k--) hb[b][k] = hb[b][k-1];
            hb[b][0] = raw[b];
            todos = 1'b1;
            for (int k = 2; k <= DEB + 1; k++) if (hb[b][k] == fl[b]) todos = 1'b0;
            fl_ant[b] = fl[b];
            if (todos) fl[b] = ~fl[b];
        end
        hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = modo_desc;
        dir    = hm[2];
        carga  = ev[2];
        pausa  = ev[1] && !ev[2];
        inicio = ev[0] && !ev[1] && !ev[2];
        ld     = (int'(valor_carga) >= MOD) ? MOD - 1 : int'(valor_carga);
        term   = dir ? 0 : MOD - 1;
        passo  = dir ? MOD - 1 : 1;
        for (int i = 0; i < 2; i++) begin
            cic = (i == 0);
            volta = 1'b0;
            mtk[i] = 1'b0;
            if (carga) begin
                ms[i] = ld; mst[i] = 0;
            end else if (mst[i] == 0) begin
                if (inicio) mst[i] = 1;
            end else if (mst[i] == 1) begin
                if (mpr[i] == DIV - 1) begin
                    mtk[i] = 1'b1;
                    mpr[i] = 0;
                    if (!cic && ms[i] == term) mst[i] = 3;
                    else begin
                        volta = (ms[i] == term);
                        ms[i] = (ms[i] + passo) % MOD;
                    end
                end else mpr[i]++;
                if (mst[i] == 1 && pausa) mst[i] = 2;
            end else if (mst[i] == 2) begin
                if (pausa || inicio) mst[i] = 1;
            end else if (inicio) begin
                ms[i] = dir ? MOD - 1 : 0; mst[i] = 1;
            end
            if (mst[i] == 0 || mst[i] == 3) mpr[i] = 0;
            mfm[i] = cic ? volta : (mst[i] == 3);
        end
    endtask
    task automatic compara();
        verifica("S_cic", s_c, ms[0]);
        verifica("estado_cic", st_c, mst[0]);
        verifica("tick_cic", tk_c, mtk[0]);
        verifica("fim_cic", fm_c, mfm[0]);
        verifica("S_fim", s_f, ms[1]);
        verifica("estado_fim", st_f, mst[1]);
        verifica("tick_fim", tk_f, mtk[1]);
        verifica("fim_fim", fm_f, mfm[1]);
    endtask
    task automatic ciclo();
        @(posedge clock);
        passo_modelo();
        @(negedge clock);
        compara();
    endtask
    task automatic espera(input int n);
        repeat (n) ciclo();
    endtask
    task automatic pressiona(input bit i, input bit p, input bit c, input int n);
        botao_inicio = i; botao_pausa = p; botao_carga = c;
        espera(n);
        botao_inicio = 1'b0; botao_pausa = 1'b0; botao_carga = 1'b0;
    endtask
    initial begin
        int ntk, nfm;
        reset_modelo();
        repeat (2) @(negedge clock);
        compara();
        verifica("reset_S", s_c, 0);
        verifica("reset_estado", st_c, 0);
        reset = 1'b0;
        // 1: short press is filtered out, long press gives one start
        pressiona(1, 0, 0, 2);
        espera(10);
        verifica("t1_curto", st_c, 0);
        pressiona(1, 0, 0, 6);
        verifica("t1_longo", st_c, 1);
        // 2: full up-count cycle from 0
        ntk = 0; nfm = 0;
        for (int k = 0; k < 40; k++) begin
            ciclo();
            ntk += int'(tk_c);
            nfm += int'(fm_c);
        end
        verifica("t2_ticks", ntk, 10);
        verifica("t2_pulsos_fim", nfm, 1);
        verifica("t2_S_volta", s_c, 0);
        verifica("t2_fim_estado", st_f, 3);
        verifica("t2_fim_S", s_f, 9);
        // 3: non-cyclic down count from 3 ends in FIM, restart from MODULO-1
        modo_desc = 1'b1; valor_carga = 4'd3;
        espera(4);
        pressiona(0, 0, 1, 6);
        verifica("t3_carga", s_f, 3);
        espera(8);
        pressiona(1, 0, 0, 6);
        espera(20);
        verifica("t3_estado_fim", st_f, 3);
        verifica("t3_S_fim", s_f, 0);
        verifica("t3_nivel_fim", fm_f, 1);
        pressiona(1, 0, 0, 6);
        verifica("t3_reinicio_S", s_f, 9);
        verifica("t3_reinicio_estado", st_f, 1);
        espera(8);
        // 4: saturating load, then carga+inicio together while counting
        valor_carga = 4'd12;
        pressiona(0, 0, 1, 6);
        verifica("t4_satura", s_c, 9);
        verifica("t4_estado", st_c, 0);
        espera(8);
        pressiona(1, 0, 0, 6);
        espera(8);
        valor_carga = 4'd5;
        pressiona(1, 0, 1, 6);
        verifica("t4_simult_S", s_c, 5);
        verifica("t4_simult_estado", st_c, 0);
        espera(8);
        // 5: pause with prescaler at 2, resume ticks two cycles later
        pressiona(1, 0, 0, 6);
        pressiona(0, 1, 0, 6);
        verifica("t5_pausado", st_c, 2);
        espera(20);
        verifica("t5_S_pausa", s_c, 4);
        pressiona(0, 1, 0, 6);
        verifica("t5_retoma", st_c, 1);
        ciclo();
        verifica("t5_tick_r1", tk_c, 0);
        ciclo();
        verifica("t5_tick_r2", tk_c, 1);
        verifica("t5_S_r2", s_c, 3);
        // 6: asynchronous reset mid-count
        espera(7);
        #2 reset = 1'b1;
        reset_modelo();
        #1;
        verifica("t6_S", s_c, 0);
        verifica("t6_estado", st_c, 0);
        verifica("t6_fim", fm_c, 0);
        verifica("t6_tick", tk_c, 0);
        verifica("t6_S_fim", s_f, 0);
        @(negedge clock);
        reset = 1'b0;
        espera(20);
        verifica("t6_parado", st_c, 0);
        // random button traffic, glitches, direction changes and loads
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) modo_desc = ~modo_desc;
            valor_carga = 4'($urandom_range(0, 15));
            pressiona(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 5) == 0), $urandom_range(1, 8));
            espera($urandom_range(0, 25));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
